controle_multiciclo: RTL and testbench

Multicycle control unit for the ProcessadorFinal datapath (register bank + ULA). It accepts one 32-bit instruction at a time through a valid/ready handshake and decodes it. It then sequences the datapath control lines (SumZero, ULAData, ALUSrc, ALUOp, RegWrite, NOP, StackOP, JAL) and register addresses over FETCH/DECODE/EXEC/WB states. It also issues PC-update pulses to the fetch stage.

---
 rtl/controle_multiciclo.sv | 186 ++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the ProcessadorFinal datapath.
// Accepts one instruction per FETCH through a valid/ready handshake, then
// steps DECODE -> EXEC -> WB, driving register addresses, ALU controls and
// PC-update pulses. Outputs depend only on the state and the latched IR;
// the exception is Zero, which steers branch_taken/pc_inc in EXEC of BEQ.
// While reset_n is low every output is forced to 0.
module controle_multiciclo #(
    parameter int REGW  = 6,
    parameter int DATAW = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DATAW-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             Zero,
    output logic [REGW-1:0]  RS,
    output logic [REGW-1:0]  RT,
    output logic [REGW-1:0]  RD,
    output logic [DATAW-1:0] imediato,
    output logic [3:0]       ALUOp,
    output logic             SumZero,
    output logic             ULAData,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             NOP,
    output logic             StackOP,
    output logic             JAL,
    output logic             pc_inc,
    output logic             branch_taken,
    output logic             illegal
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h05;
    localparam logic [5:0] OP_BEQ  = 6'h06;
    localparam logic [5:0] OP_MOV  = 6'h07;
    localparam logic [5:0] OP_PUSH = 6'h08;
    localparam logic [5:0] OP_JAL  = 6'h09;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t           state_q, state_d;
    logic [DATAW-1:0] ir_q, ir_d;
    logic             illegal_q, illegal_d;

    logic [5:0]       op;
    logic             op_legal;
    logic             is_nop_like;
    logic             writes_reg;
    logic [3:0]       alu_op_dec;
    logic [DATAW-1:0] imm_dec;

    // Instruction decode from the latched IR only
    always_comb begin
        op          = ir_q[31:26];
        op_legal    = (op <= OP_JAL);
        is_nop_like = (op == OP_NOP) || !op_legal;
        writes_reg  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_OR)  || (op == OP_ADDI) || (op == OP_MOV);
        case (op)
            OP_ADD, OP_ADDI, OP_MOV, OP_PUSH, OP_JAL: alu_op_dec = ALU_ADD;
            OP_SUB, OP_BEQ:                           alu_op_dec = ALU_SUB;
            OP_AND:                                   alu_op_dec = ALU_AND;
            OP_OR:                                    alu_op_dec = ALU_OR;
            default:                                  alu_op_dec = 4'b0000;
        endcase
        // PUSH pre-decrements the stack pointer by one word
        if (op == OP_PUSH)
            imm_dec = {{(DATAW-2){1'b1}}, 2'b00};
        else if (op == OP_JAL)
            imm_dec = {{(DATAW-26){ir_q[25]}}, ir_q[25:0]};
        else
            imm_dec = {{(DATAW-14){ir_q[13]}}, ir_q[13:0]};
    end

    // Next state, IR load, sticky illegal flag and all outputs
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        illegal_d    = illegal_q;
        instr_ready  = 1'b0;
        RS           = '0;
        RT           = '0;
        RD           = '0;
        imediato     = '0;
        ALUOp        = 4'b0000;
        SumZero      = 1'b0;
        ULAData      = 1'b0;
        ALUSrc       = 1'b0;
        RegWrite     = 1'b0;
        NOP          = 1'b0;
        StackOP      = 1'b0;
        JAL          = 1'b0;
        pc_inc       = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;

        if (reset_n) begin
            illegal = illegal_q;
            // Datapath fields are held constant from DECODE through WB
            if (state_q != S_FETCH) begin
                RS       = REGW'(ir_q[25:20]);
                RT       = REGW'(ir_q[19:14]);
                RD       = (op == OP_ADDI) ? REGW'(ir_q[19:14]) : REGW'(ir_q[13:8]);
                imediato = imm_dec;
                ALUOp    = alu_op_dec;
                SumZero  = (op == OP_MOV);
                ALUSrc   = (op == OP_ADDI) || (op == OP_PUSH);
            end

            case (state_q)
                S_FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        ir_d    = instr;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_nop_like) begin
                        NOP     = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                        if (!op_legal) begin
                            illegal_d = 1'b1;
                            illegal   = 1'b1;
                        end
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_BEQ) begin
                        pc_inc       = ~Zero;
                        branch_taken = Zero;
                        state_d      = S_FETCH;
                    end else begin
                        if (op == OP_PUSH) begin
                            ULAData = 1'b1;
                            StackOP = 1'b1;
                        end
                        state_d = S_WB;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                    if (op == OP_JAL) begin
                        JAL          = 1'b1;
                        RegWrite     = 1'b1;
                        RD           = {REGW{1'b1}};
                        branch_taken = 1'b1;
                    end else begin
                        pc_inc   = 1'b1;
                        RegWrite = writes_reg;
                        StackOP  = (op == OP_PUSH);
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State, IR and sticky flag registers; reset aborts any instruction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: a cycle-index model of each instruction's
// output timeline, checked every falling edge, plus literal spot checks.
module tb_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        Zero = 1'b0;
    logic        instr_ready;
    logic [5:0]  RS, RT, RD;
    logic [31:0] imediato;
    logic [3:0]  ALUOp;
    logic        SumZero, ULAData, ALUSrc, RegWrite, NOP, StackOP, JAL;
    logic        pc_inc, branch_taken, illegal;

    int n_cmp = 0;
    int n_fail = 0;

    controle_multiciclo #(.REGW(6), .DATAW(32)) dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Zero(Zero), .RS(RS), .RT(RT), .RD(RD),
        .imediato(imediato), .ALUOp(ALUOp), .SumZero(SumZero), .ULAData(ULAData),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .NOP(NOP), .StackOP(StackOP), .JAL(JAL),
        .pc_inc(pc_inc), .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // ---------------- model: k = cycles since accept (0 = waiting) ----------
    logic [31:0] m_ir = '0;
    int          m_k = 0;
    logic        m_ill = 1'b0;

    function automatic int latency(input logic [31:0] ir);
        logic [5:0] op = ir[31:26];
        if (op == 6'd0 || op > 6'd9) return 2;
        if (op == 6'd6) return 3;
        return 4;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_k   <= 0;
            m_ill <= 1'b0;
        end else if (m_k == 0) begin
            if (instr_valid) begin
                m_ir <= instr;
                m_k  <= 1;
            end
        end else begin
            if (m_k == 1 && m_ir[31:26] > 6'd9) m_ill <= 1'b1;
            m_k <= (m_k >= latency(m_ir) - 1) ? 0 : m_k + 1;
        end
    end

    // {ready, RS, RT, RD, imm, ALUOp, SumZero, ULAData, ALUSrc, RegWrite,
    //  NOP, StackOP, JAL, pc_inc, branch_taken, illegal}
    function automatic logic [64:0] expect_out(input logic [31:0] ir, input int k,
                                               input logic z, input logic ill,
                                               input logic rn);
        logic [5:0]  op = ir[31:26];
        logic        legal = (op <= 6'd9);
        logic        rdy = 0, sz = 0, ud = 0, as = 0, rw = 0, np = 0, so = 0, jl = 0;
        logic        pi = 0, bt = 0, il;
        logic [5:0]  rs = 0, rt = 0, rd = 0;
        logic [31:0] im = 0;
        logic [3:0]  ao = 0;
        il = ill;
        if (!rn) return '0;
        if (k == 0) rdy = 1;
        else begin
            rs = ir[25:20];
            rt = ir[19:14];
            rd = (op == 6'd5) ? ir[19:14] : ir[13:8];
            if (op == 6'd8)      im = 32'hFFFF_FFFC;
            else if (op == 6'd9) im = {{6{ir[25]}}, ir[25:0]};
            else                 im = {{18{ir[13]}}, ir[13:0]};
            case (op)
                6'd1, 6'd5, 6'd7, 6'd8, 6'd9: ao = 4'b0010;
                6'd2, 6'd6:                   ao = 4'b0110;
                6'd4:                         ao = 4'b0001;
                default:                      ao = 4'b0000;
            endcase
            sz = (op == 6'd7);
            as = (op == 6'd5 || op == 6'd8);
        end
        if (k == 1 && (op == 6'd0 || !legal)) begin
            np = 1; pi = 1;
            if (!legal) il = 1;
        end
        if (k == 2) begin
            if (op == 6'd6) begin pi = ~z; bt = z; end
            if (op == 6'd8) begin ud = 1; so = 1; end
        end
        if (k == 3) begin
            if (op == 6'd9) begin jl = 1; rw = 1; rd = 6'd63; bt = 1; end
            else begin
                pi = 1;
                rw = (op >= 6'd1 && op <= 6'd5) || op == 6'd7;
                so = (op == 6'd8);
            end
        end
        return {rdy, rs, rt, rd, im, ao, sz, ud, as, rw, np, so, jl, pi, bt, il};
    endfunction

    function automatic logic [64:0] dut_out();
        return {instr_ready, RS, RT, RD, imediato, ALUOp, SumZero, ULAData, ALUSrc,
                RegWrite, NOP, StackOP, JAL, pc_inc, branch_taken, illegal};
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        logic [64:0] e, g;
        e = expect_out(m_ir, m_k, Zero, m_ill, reset_n);
        g = dut_out();
        n_cmp++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t k=%0d got=%h want=%h", $time, m_k, g, e);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        @(negedge clock);
        while (!instr_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!instr_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout got=0 want=1");
        end
        #1 instr = w; instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [5:0] rs,
                                          input logic [5:0] rt, input logic [5:0] rd);
        return {op, rs, rt, rd, 8'h00};
    endfunction

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_ready", {31'd0, instr_ready}, 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("release_ready", {31'd0, instr_ready}, 32'd1);

        // ADD rs=3 rt=4 rd=5
        send(rtype(6'h01, 6'd3, 6'd4, 6'd5));
        @(negedge clock);
        chk("add_fields", {8'd0, 2'd0, RS, RT, RD}, {8'd0, 2'd0, 6'd3, 6'd4, 6'd5});
        chk("add_aluop", {27'd0, ALUOp, ALUSrc}, {27'd0, 4'b0010, 1'b0});
        @(negedge clock);
        chk("add_rw_c2", {31'd0, RegWrite}, 32'd0);
        @(negedge clock);
        chk("add_rw_c3", {31'd0, RegWrite}, 32'd1);
        @(negedge clock);
        chk("add_ready_c4", {31'd0, instr_ready}, 32'd1);

        // ADDI rs=3 rd(rt field)=6 imm=-5
        send({6'h05, 6'd3, 6'd6, 14'h3FFB});
        @(negedge clock);
        chk("addi_imm", imediato, 32'hFFFF_FFFB);
        chk("addi_src_rd", {25'd0, ALUSrc, RD}, {25'd0, 1'b1, 6'd6});

        // BEQ taken
        Zero = 1'b1;
        send({6'h06, 6'd1, 6'd2, 14'h0010});
        repeat (2) @(negedge clock);
        chk("beq_z1", {30'd0, branch_taken, pc_inc}, {30'd0, 2'b10});
        @(negedge clock);
        chk("beq_ready_c3", {31'd0, instr_ready}, 32'd1);

        // BEQ not taken
        Zero = 1'b0;
        send({6'h06, 6'd1, 6'd2, 14'h0010});
        repeat (2) @(negedge clock);
        chk("beq_z0", {30'd0, branch_taken, pc_inc}, {30'd0, 2'b01});

        // MOV rt=4 rd=7
        send(rtype(6'h07, 6'd0, 6'd4, 6'd7));
        @(negedge clock);
        chk("mov_sumzero", {31'd0, SumZero}, 32'd1);
        repeat (2) @(negedge clock);
        chk("mov_rw", {31'd0, RegWrite}, 32'd1);

        // PUSH
        send(rtype(6'h08, 6'd2, 6'd9, 6'd0));
        repeat (2) @(negedge clock);
        chk("push_exec", {30'd0, ULAData, StackOP}, {30'd0, 2'b11});
        chk("push_imm", imediato, 32'hFFFF_FFFC);
        @(negedge clock);
        chk("push_wb", {30'd0, StackOP, RegWrite}, {30'd0, 2'b10});

        // JAL to a negative target
        send({6'h09, 26'h3FF_FF00});
        @(negedge clock);
        chk("jal_imm", imediato, 32'hFFFF_FF00);
        repeat (2) @(negedge clock);
        chk("jal_wb", {23'd0, JAL, branch_taken, pc_inc, RD}, {23'd0, 3'b110, 6'd63});

        // NOP opcode: two-cycle turnaround
        send(32'h0000_0000);
        @(negedge clock);
        chk("nop_dec", {30'd0, NOP, pc_inc}, {30'd0, 2'b11});
        @(negedge clock);
        chk("nop_ready_c2", {31'd0, instr_ready}, 32'd1);

        // Illegal opcode, then ADD keeps the sticky flag
        send({6'h3F, 26'h0});
        @(negedge clock);
        chk("ill_dec", {29'd0, NOP, pc_inc, illegal}, {29'd0, 3'b111});
        send(rtype(6'h01, 6'd1, 6'd1, 6'd1));
        repeat (3) @(negedge clock);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);

        // Async reset during EXEC of ADD
        send(rtype(6'h01, 6'd3, 6'd4, 6'd5));
        @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk("rst_async_outs", {31'd0, |dut_out()}, 32'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_release", {29'd0, instr_ready, RegWrite, illegal}, {29'd0, 3'b100});
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
